// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write port of the loader
interface imem_loader_if #(
    parameter int ADDR_W = 6
) ();
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    // slave: the loader; master: byte source plus memory-side observer
    modport slave (
        input  in_valid, in_byte,
        output in_ready, wr_en, wr_addr, wr_data
    );
    modport master (
        output in_valid, in_byte,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - assembles a counted little-endian byte stream into instruction-memory word writes
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          core_hold,
    output logic          load_done,
    output logic          load_err
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HDR_LO = 3'd1;
    localparam logic [2:0] HDR_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERROR  = 3'd6;

    localparam logic [15:0] DEPTH_N = 16'(DEPTH);

    logic [2:0]        state;
    logic [1:0]        idx;
    logic [15:0]       count;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              accept;
    logic [15:0]       n_full;
    logic              last_word;

    assign accept    = bus.in_valid && bus.in_ready;
    // Full word count as it will be once the high header byte lands
    assign n_full    = {bus.in_byte, count[7:0]};
    assign last_word = ({{(16-ADDR_W){1'b0}}, wr_addr} == (count - 16'd1));

    assign bus.in_ready = (state == HDR_LO) || (state == HDR_HI) || (state == DATA);
    assign bus.wr_en    = (state == WRITE);
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = wr_data;
    assign core_hold    = (state != DONE);
    assign load_done    = (state == DONE);
    assign load_err     = (state == ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= 2'd0;
            count   <= 16'd0;
            wr_addr <= '0;
            wr_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= HDR_LO;
                end
                HDR_LO: begin
                    if (accept) begin
                        count[7:0] <= bus.in_byte;
                        state      <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (accept) begin
                        count[15:8] <= bus.in_byte;
                        wr_addr     <= '0;
                        idx         <= 2'd0;
                        if (n_full == 16'd0)
                            state <= DONE;
                        else if (n_full > DEPTH_N)
                            state <= ERROR;
                        else
                            state <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        wr_data[{idx, 3'b000} +: 8] <= bus.in_byte;
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) state <= WRITE;
                    end
                end
                WRITE: begin
                    if (last_word) begin
                        state <= DONE;
                    end else begin
                        wr_addr <= wr_addr + 1'b1;
                        state   <= DATA;
                    end
                end
                DONE, ERROR: begin
                    if (start) state <= HDR_LO;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
